// File: rtl/byte_mem_slave_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | byte_mem_slave_if : request/response bus for byte_mem_slave          |
// | rev 1.0                                                              |
// +--------------------------------------------------------------------+
interface byte_mem_slave_if #(
  parameter int addr_width = 4,
  parameter int mem_data   = 8
);
  logic                  s_cs;
  logic                  s_write;
  logic [addr_width+3:0] s_addr;
  logic [mem_data-1:0]   s_wdata;
  logic [mem_data-1:0]   m_rdata;
  logic                  m_ready;
  logic                  m_error;

  modport master (
    output s_cs, s_write, s_addr, s_wdata,
    input  m_rdata, m_ready, m_error
  );

  modport slave (
    input  s_cs, s_write, s_addr, s_wdata,
    output m_rdata, m_ready, m_error
  );
endinterface
`default_nettype wire

// File: rtl/byte_mem_slave.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | byte_mem_slave : byte-wide memory slave with optional wait states    |
// | optional write protection of the top region via MEM_WPROT_EN        |
// | rev 1.0                                                              |
// +--------------------------------------------------------------------+
module byte_mem_slave #(
  parameter int addr_width  = 4,
  parameter int mem_data    = 8,
  parameter int wait_states = 0
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  byte_mem_slave_if.slave  bus
);

  localparam int BW    = addr_width + 4;
  localparam int DEPTH = 2 ** BW;

  logic [mem_data-1:0] mem [DEPTH];

  logic [BW-1:0]       w_acc_addr;
  logic [mem_data-1:0] w_acc_wdata;
  logic                w_we;
  logic                w_prot;

`ifdef MEM_WPROT_EN
  assign w_prot = &w_acc_addr[BW-1:4];
`else
  assign w_prot = 1'b0;
`endif

  // Storage is deliberately left out of reset.
  always_ff @(posedge PCLK) begin
    if (w_we) begin
      mem[w_acc_addr] <= w_acc_wdata;
    end
  end

  generate
    if (wait_states == 0) begin : g_comb
      assign w_acc_addr  = bus.s_addr;
      assign w_acc_wdata = bus.s_wdata;
      assign w_we        = PRESETn & bus.s_cs & bus.s_write & ~w_prot;

      assign bus.m_ready = PRESETn & bus.s_cs;
      assign bus.m_error = PRESETn & bus.s_cs & bus.s_write & w_prot;
      assign bus.m_rdata = (PRESETn & bus.s_cs & ~bus.s_write) ? mem[bus.s_addr] : '0;
    end else begin : g_fsm
      typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
      } state_t;

      localparam logic [3:0] CNT_LOAD = 4'(wait_states - 1);

      state_t              state_q, state_d;
      logic [3:0]          cnt_q, cnt_d;
      logic [BW-1:0]       addr_q, addr_d;
      logic                wr_q, wr_d;
      logic [mem_data-1:0] wdata_q, wdata_d;
      logic                ready_q, ready_d;
      logic                err_q, err_d;
      logic [mem_data-1:0] rdata_q, rdata_d;

      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        rdata_d = '0;
        case (state_q)
          ST_IDLE: begin
            if (bus.s_cs) begin
              state_d = ST_WAIT;
              cnt_d   = CNT_LOAD;
              addr_d  = bus.s_addr;
              wr_d    = bus.s_write;
              wdata_d = bus.s_wdata;
            end
          end
          ST_WAIT: begin
            if (!bus.s_cs) begin
              state_d = ST_IDLE;
            end else if (cnt_q == 4'd0) begin
              // Response is registered here so it appears in READY.
              state_d = ST_READY;
              ready_d = 1'b1;
              err_d   = wr_q & w_prot;
              rdata_d = wr_q ? '0 : mem[addr_q];
            end else begin
              cnt_d = cnt_q - 4'd1;
            end
          end
          ST_READY: begin
            if (bus.s_cs) begin
              state_d = ST_WAIT;
              cnt_d   = CNT_LOAD;
              addr_d  = bus.s_addr;
              wr_d    = bus.s_write;
              wdata_d = bus.s_wdata;
            end else begin
              state_d = ST_IDLE;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end

      always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
          state_q <= ST_IDLE;
          cnt_q   <= 4'd0;
          addr_q  <= '0;
          wr_q    <= 1'b0;
          wdata_q <= '0;
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= '0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          addr_q  <= addr_d;
          wr_q    <= wr_d;
          wdata_q <= wdata_d;
          ready_q <= ready_d;
          err_q   <= err_d;
          rdata_q <= rdata_d;
        end
      end

      assign w_acc_addr  = addr_q;
      assign w_acc_wdata = wdata_q;
      assign w_we        = (state_q == ST_READY) & wr_q & ~w_prot;

      assign bus.m_ready = ready_q;
      assign bus.m_error = err_q;
      assign bus.m_rdata = rdata_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_byte_mem_slave.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_byte_mem_slave : directed bench, zero-wait and 3-wait instances   |
// | rev 1.0                                                              |
// +--------------------------------------------------------------------+
module tb_byte_mem_slave;

  logic PCLK = 1'b0;
  logic rst0_n = 1'b1;
  logic rst3_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 PCLK = ~PCLK;

  byte_mem_slave_if #(.addr_width(4), .mem_data(8)) bus0 ();
  byte_mem_slave_if #(.addr_width(4), .mem_data(8)) bus3 ();

  byte_mem_slave #(.addr_width(4), .mem_data(8), .wait_states(0)) u_dut0 (
    .PCLK    (PCLK),
    .PRESETn (rst0_n),
    .bus     (bus0)
  );

  byte_mem_slave #(.addr_width(4), .mem_data(8), .wait_states(3)) u_dut3 (
    .PCLK    (PCLK),
    .PRESETn (rst3_n),
    .bus     (bus3)
  );

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // One zero-wait cycle: drive, sample at the falling edge, advance.
  task automatic cyc0(input string tag, input logic cs, input logic wr,
                      input logic [7:0] addr, input logic [7:0] wdata,
                      input logic exp_rdy, input logic [7:0] exp_rd, input logic exp_err);
    bus0.s_cs    = cs;
    bus0.s_write = wr;
    bus0.s_addr  = addr;
    bus0.s_wdata = wdata;
    @(negedge PCLK);
    check_val({tag, "_rdy"}, 16'(bus0.m_ready), 16'(exp_rdy));
    check_val({tag, "_rd"},  16'(bus0.m_rdata), 16'(exp_rd));
    check_val({tag, "_err"}, 16'(bus0.m_error), 16'(exp_err));
    @(posedge PCLK); #1;
  endtask

  // Full access on the wait-state instance starting from IDLE.
  task automatic acc3(input string tag, input logic wr, input logic [7:0] addr,
                      input logic [7:0] wdata, input logic [7:0] exp_rd, input logic exp_err);
    int   lowcnt = 0;
    logic got = 1'b0;
    logic [7:0] rd = '0;
    logic er = 1'b0;
    bus3.s_cs    = 1'b1;
    bus3.s_write = wr;
    bus3.s_addr  = addr;
    bus3.s_wdata = wdata;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge PCLK);
      if (bus3.m_ready) begin
        got = 1'b1;
        rd  = bus3.m_rdata;
        er  = bus3.m_error;
        bus3.s_cs    = 1'b0;
        bus3.s_write = 1'b0;
      end else begin
        lowcnt++;
      end
      @(posedge PCLK); #1;
    end
    check_val({tag, "_done"}, 16'(got), 16'd1);
    check_val({tag, "_lat"},  16'(lowcnt), 16'd4);
    check_val({tag, "_rd"},   16'(rd), 16'(exp_rd));
    check_val({tag, "_err"},  16'(er), 16'(exp_err));
  endtask

  initial begin
    bus0.s_cs = 1'b1; bus0.s_write = 1'b0; bus0.s_addr = 8'h12; bus0.s_wdata = '0;
    bus3.s_cs = 1'b1; bus3.s_write = 1'b0; bus3.s_addr = 8'h12; bus3.s_wdata = '0;
    #1;
    rst0_n = 1'b0;
    rst3_n = 1'b0;
    @(negedge PCLK);
    check_val("rst0_rdy", 16'(bus0.m_ready), 16'd0);
    check_val("rst0_rd",  16'(bus0.m_rdata), 16'd0);
    check_val("rst3_rdy", 16'(bus3.m_ready), 16'd0);
    check_val("rst3_rd",  16'(bus3.m_rdata), 16'd0);
    @(posedge PCLK); #1;
    bus0.s_cs = 1'b0;
    bus3.s_cs = 1'b0;
    @(posedge PCLK); #1;
    rst0_n = 1'b1;
    rst3_n = 1'b1;

    // Zero-wait instance
    cyc0("wr12", 1, 1, 8'h12, 8'hA5, 1, 8'h00, 0);
    cyc0("rd12", 1, 0, 8'h12, 8'h00, 1, 8'hA5, 0);
    cyc0("idle", 0, 0, 8'h12, 8'h00, 0, 8'h00, 0);
    for (int i = 0; i < 16; i++) cyc0("wr3x", 1, 1, 8'(8'h30 + i), 8'(i), 1, 8'h00, 0);
    for (int i = 0; i < 16; i++) cyc0("rd3x", 1, 0, 8'(8'h30 + i), 8'h00, 1, 8'(i), 0);
    cyc0("b2b_w1", 1, 1, 8'h40, 8'h11, 1, 8'h00, 0);
    cyc0("b2b_r1", 1, 0, 8'h40, 8'h00, 1, 8'h11, 0);
    cyc0("b2b_w2", 1, 1, 8'h40, 8'h22, 1, 8'h00, 0);
    cyc0("b2b_r2", 1, 0, 8'h40, 8'h00, 1, 8'h22, 0);
    cyc0("wrEF",   1, 1, 8'hEF, 8'h66, 1, 8'h00, 0);
    cyc0("rdEF",   1, 0, 8'hEF, 8'h00, 1, 8'h66, 0);
`ifdef MEM_WPROT_EN
    cyc0("wprotF4", 1, 1, 8'hF4, 8'h55, 1, 8'h00, 1);
    cyc0("wprotF0", 1, 1, 8'hF0, 8'h55, 1, 8'h00, 1);
    bus0.s_cs = 1'b1; bus0.s_write = 1'b0; bus0.s_addr = 8'hF4;
    @(negedge PCLK);
    check_val("rprot_rdy", 16'(bus0.m_ready), 16'd1);
    check_val("rprot_err", 16'(bus0.m_error), 16'd0);
    @(posedge PCLK); #1;
`else
    cyc0("wrF4", 1, 1, 8'hF4, 8'h55, 1, 8'h00, 0);
    cyc0("rdF4", 1, 0, 8'hF4, 8'h00, 1, 8'h55, 0);
`endif
    rst0_n = 1'b0;
    bus0.s_cs = 1'b1; bus0.s_write = 1'b1; bus0.s_addr = 8'h12; bus0.s_wdata = 8'hEE;
    @(negedge PCLK);
    check_val("rstw_rdy", 16'(bus0.m_ready), 16'd0);
    check_val("rstw_err", 16'(bus0.m_error), 16'd0);
    @(posedge PCLK); #1;
    rst0_n = 1'b1;
    cyc0("rstw_rd", 1, 0, 8'h12, 8'h00, 1, 8'hA5, 0);
    bus0.s_cs = 1'b0;

    // Wait-state instance: preload
    acc3("p12", 1, 8'h12, 8'hA5, 8'h00, 0);
    acc3("p13", 1, 8'h13, 8'h5A, 8'h00, 0);
    acc3("p20", 1, 8'h20, 8'h44, 8'h00, 0);

    // Held chip select: two back-to-back reads, second captured at READY
    bus3.s_cs = 1'b1; bus3.s_write = 1'b0; bus3.s_addr = 8'h12;
    @(negedge PCLK);
    check_val("hold_idle", 16'(bus3.m_ready), 16'd0);
    @(posedge PCLK); #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge PCLK);
      check_val("hold_w1_rdy", 16'(bus3.m_ready), 16'd0);
      check_val("hold_w1_rd",  16'(bus3.m_rdata), 16'd0);
      @(posedge PCLK); #1;
    end
    @(negedge PCLK);
    check_val("hold_r1_rdy", 16'(bus3.m_ready), 16'd1);
    check_val("hold_r1_rd",  16'(bus3.m_rdata), 16'hA5);
    check_val("hold_r1_err", 16'(bus3.m_error), 16'd0);
    bus3.s_addr = 8'h13;
    @(posedge PCLK); #1;
    @(negedge PCLK);
    check_val("hold_w2a", 16'(bus3.m_ready), 16'd0);
    bus3.s_addr = 8'h12;
    @(posedge PCLK); #1;
    for (int k = 0; k < 2; k++) begin
      @(negedge PCLK);
      check_val("hold_w2b", 16'(bus3.m_ready), 16'd0);
      @(posedge PCLK); #1;
    end
    @(negedge PCLK);
    check_val("hold_r2_rdy", 16'(bus3.m_ready), 16'd1);
    check_val("hold_r2_rd",  16'(bus3.m_rdata), 16'h5A);
    bus3.s_cs = 1'b0;
    @(posedge PCLK); #1;
    @(negedge PCLK);
    check_val("hold_end_rdy", 16'(bus3.m_ready), 16'd0);
    check_val("hold_end_rd",  16'(bus3.m_rdata), 16'd0);
    @(posedge PCLK); #1;

    // Abort a write by dropping chip select in WAIT
    bus3.s_cs = 1'b1; bus3.s_write = 1'b1; bus3.s_addr = 8'h12; bus3.s_wdata = 8'h77;
    @(posedge PCLK); #1;
    @(negedge PCLK);
    check_val("abort_w1", 16'(bus3.m_ready), 16'd0);
    @(posedge PCLK); #1;
    bus3.s_cs = 1'b0; bus3.s_write = 1'b0;
    @(negedge PCLK);
    check_val("abort_w2", 16'(bus3.m_ready), 16'd0);
    @(posedge PCLK); #1;
    @(negedge PCLK);
    check_val("abort_w3", 16'(bus3.m_ready), 16'd0);
    @(posedge PCLK); #1;
    acc3("abort_rd", 0, 8'h12, 8'h00, 8'hA5, 0);

    // Reset during WAIT of a write
    bus3.s_cs = 1'b1; bus3.s_write = 1'b1; bus3.s_addr = 8'h20; bus3.s_wdata = 8'h99;
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    rst3_n = 1'b0;
    #1;
    check_val("rstwait_rdy", 16'(bus3.m_ready), 16'd0);
    check_val("rstwait_rd",  16'(bus3.m_rdata), 16'd0);
    check_val("rstwait_err", 16'(bus3.m_error), 16'd0);
    @(posedge PCLK); #1;
    bus3.s_cs = 1'b0; bus3.s_write = 1'b0;
    rst3_n = 1'b1;
    acc3("rstwait_rd20", 0, 8'h20, 8'h00, 8'h44, 0);

    // Reset during READY clears the registered outputs at once
    bus3.s_cs = 1'b1; bus3.s_write = 1'b0; bus3.s_addr = 8'h12;
    repeat (4) begin
      @(posedge PCLK); #1;
    end
    @(negedge PCLK);
    check_val("rstrdy_pre", 16'(bus3.m_ready), 16'd1);
    rst3_n = 1'b0;
    #1;
    check_val("rstrdy_rdy", 16'(bus3.m_ready), 16'd0);
    check_val("rstrdy_rd",  16'(bus3.m_rdata), 16'd0);
    bus3.s_cs = 1'b0;
    @(posedge PCLK); #1;
    rst3_n = 1'b1;
    acc3("rstrdy_rd12", 0, 8'h12, 8'h00, 8'hA5, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
